// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage OTTER pipeline.
// Resolves load-use, redirect and slow-data-memory hazards that forwarding cannot.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 15,
  parameter int CNT_W             = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_USES_RS1,
  input  logic             ID_USES_RS2,
  input  logic [4:0]       EX_RD,
  input  logic             EX_MEMREAD,
  input  logic [1:0]       EX_PCSOURCE,
  input  logic             MEM_REQ,
  input  logic             MEM_READY,
  output logic             PC_WRITE,
  output logic             IF_ID_WRITE,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             PIPE_HOLD,
  output logic             BUS_ERR,
  output logic [CNT_W-1:0] STALL_COUNT,
  output logic [CNT_W-1:0] FLUSH_COUNT
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MEM_WAIT   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    C_PASS  = 2'd0,
    C_HOLD  = 2'd1,
    C_FLUSH = 2'd2,
    C_STALL = 2'd3
  } cls_t;

  localparam logic [7:0]       TIMEOUT_C = 8'(MEM_TIMEOUT);
  localparam logic [7:0]       LS_LAST_C = 8'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             mask_q, mask_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  cls_t             cls;
  logic             do_run;

  logic load_use, redirect, mem_wait;

  assign load_use = EX_MEMREAD && (EX_RD != 5'd0) &&
                    ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                     (ID_USES_RS2 && (ID_RS2 == EX_RD)));
  assign redirect = (EX_PCSOURCE != 2'd0);
  // mask_q abandons the access for the single cycle after a timeout
  assign mem_wait = MEM_REQ && !MEM_READY && !mask_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_err_d   = bus_err_q;
    mask_d      = 1'b0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    cls         = C_PASS;
    do_run      = 1'b0;

    case (state_q)
      S_MEM_WAIT: begin
        if (mem_wait) begin
          cls = C_HOLD;
          if (cnt_q >= TIMEOUT_C) begin
            bus_err_d = 1'b1;
            mask_d    = 1'b1;
            cnt_d     = 8'd0;
            state_d   = S_RUN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          do_run = 1'b1;
        end
      end
      S_LOAD_STALL: begin
        if (mem_wait) begin
          cls = C_HOLD;
        end else if (redirect) begin
          cls         = C_FLUSH;
          flush_cnt_d = flush_cnt_q + CNT_ONE;
          cnt_d       = 8'd0;
          state_d     = S_RUN;
        end else begin
          cls         = C_STALL;
          stall_cnt_d = stall_cnt_q + CNT_ONE;
          if (cnt_q == LS_LAST_C) begin
            cnt_d   = 8'd0;
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: do_run = 1'b1;
    endcase

    if (do_run) begin
      state_d = S_RUN;
      if (mem_wait) begin
        cls     = C_HOLD;
        cnt_d   = 8'd1;
        state_d = S_MEM_WAIT;
      end else if (redirect) begin
        cls         = C_FLUSH;
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else if (load_use) begin
        cls         = C_STALL;
        stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (LOAD_STALL_CYCLES > 1) begin
          cnt_d   = 8'd1;
          state_d = S_LOAD_STALL;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_RUN;
      cnt_q       <= 8'd0;
      bus_err_q   <= 1'b0;
      mask_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
      mask_q      <= mask_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // While in reset the pipeline is held empty: fetch frozen, both latches flushed
  always_comb begin
    PC_WRITE    = 1'b1;
    IF_ID_WRITE = 1'b1;
    IF_ID_FLUSH = 1'b0;
    ID_EX_FLUSH = 1'b0;
    PIPE_HOLD   = 1'b0;
    if (!RST) begin
      PC_WRITE    = 1'b0;
      IF_ID_WRITE = 1'b0;
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end else begin
      case (cls)
        C_HOLD: begin
          PC_WRITE    = 1'b0;
          IF_ID_WRITE = 1'b0;
          PIPE_HOLD   = 1'b1;
        end
        C_FLUSH: begin
          IF_ID_FLUSH = 1'b1;
          ID_EX_FLUSH = 1'b1;
        end
        C_STALL: begin
          PC_WRITE    = 1'b0;
          IF_ID_WRITE = 1'b0;
          ID_EX_FLUSH = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUS_ERR     = bus_err_q;
  assign STALL_COUNT = stall_cnt_q;
  assign FLUSH_COUNT = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench for pipeline_hazard_ctrl: one instance with single-bubble
// load-use stalls and one with three-bubble stalls.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_u1, id_u2, ex_mr, mreq, mrdy;
  logic [1:0]  ex_pcs;

  logic        pcw1, ifw1, iff1, idf1, hold1, berr1;
  logic [15:0] sc1, fc1;
  logic        pcw3, ifw3, iff3, idf3, hold3, berr3;
  logic [15:0] sc3, fc3;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(15), .CNT_W(16)) dut1 (
    .CLK(clk), .RST(rst_n), .ID_RS1(id_rs1), .ID_RS2(id_rs2),
    .ID_USES_RS1(id_u1), .ID_USES_RS2(id_u2), .EX_RD(ex_rd), .EX_MEMREAD(ex_mr),
    .EX_PCSOURCE(ex_pcs), .MEM_REQ(mreq), .MEM_READY(mrdy),
    .PC_WRITE(pcw1), .IF_ID_WRITE(ifw1), .IF_ID_FLUSH(iff1), .ID_EX_FLUSH(idf1),
    .PIPE_HOLD(hold1), .BUS_ERR(berr1), .STALL_COUNT(sc1), .FLUSH_COUNT(fc1));

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(15), .CNT_W(16)) dut3 (
    .CLK(clk), .RST(rst_n), .ID_RS1(id_rs1), .ID_RS2(id_rs2),
    .ID_USES_RS1(id_u1), .ID_USES_RS2(id_u2), .EX_RD(ex_rd), .EX_MEMREAD(ex_mr),
    .EX_PCSOURCE(ex_pcs), .MEM_REQ(mreq), .MEM_READY(mrdy),
    .PC_WRITE(pcw3), .IF_ID_WRITE(ifw3), .IF_ID_FLUSH(iff3), .ID_EX_FLUSH(idf3),
    .PIPE_HOLD(hold3), .BUS_ERR(berr3), .STALL_COUNT(sc3), .FLUSH_COUNT(fc3));

  // control bits are {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_FLUSH, PIPE_HOLD}
  localparam logic [4:0] PASS  = 5'b11000;
  localparam logic [4:0] HOLD  = 5'b00001;
  localparam logic [4:0] FLUSH = 5'b11110;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] RSTO  = 5'b00110;

  typedef struct {
    string      name;
    bit         sel3;
    logic       rst;
    logic [4:0] rs1;  logic u1;
    logic [4:0] rs2;  logic u2;
    logic [4:0] exrd; logic mr;
    logic [1:0] pcs;
    logic       mreq; logic mrdy;
    logic [4:0] ctl;  logic be;
    int         sc;   int   fc;
  } vec_t;

  typedef struct {
    string      name;
    bit         sel3;
    logic [4:0] ctl;
    logic       be;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(string n, bit s3, logic r,
                              logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] exrd, logic mr, logic [1:0] pcs,
                              logic mq, logic md,
                              logic [4:0] ctl, logic be, int sc, int fc);
    vec_t v;
    v.name = n; v.sel3 = s3; v.rst = r;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.exrd = exrd; v.mr = mr; v.pcs = pcs; v.mreq = mq; v.mrdy = md;
    v.ctl = ctl; v.be = be; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  // idle cycle with nothing in flight
  function automatic vec_t idle(string n, bit s3, logic [4:0] ctl, logic be, int sc, int fc);
    return mk(n, s3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, ctl, be, sc, fc);
  endfunction

  function automatic vec_t memw(string n, logic md, logic [4:0] ctl, logic be, int sc, int fc);
    return mk(n, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, md, ctl, be, sc, fc);
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    logic [4:0] act_ctl;
    logic act_be;
    logic [15:0] act_sc, act_fc;
    @(negedge clk);
    rst_n = v.rst; id_rs1 = v.rs1; id_u1 = v.u1; id_rs2 = v.rs2; id_u2 = v.u2;
    ex_rd = v.exrd; ex_mr = v.mr; ex_pcs = v.pcs; mreq = v.mreq; mrdy = v.mrdy;
    e.name = v.name; e.sel3 = v.sel3; e.ctl = v.ctl; e.be = v.be;
    e.sc = 16'(v.sc); e.fc = 16'(v.fc);
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    if (e.sel3) begin
      act_ctl = {pcw3, ifw3, iff3, idf3, hold3}; act_be = berr3; act_sc = sc3; act_fc = fc3;
    end else begin
      act_ctl = {pcw1, ifw1, iff1, idf1, hold1}; act_be = berr1; act_sc = sc1; act_fc = fc1;
    end
    n_checks++;
    if (act_ctl === e.ctl && act_be === e.be && act_sc === e.sc && act_fc === e.fc)
      n_pass++;
    else
      $display("FAIL %s: got ctl=%b berr=%b stall=%0d flush=%0d, want ctl=%b berr=%b stall=%0d flush=%0d",
               e.name, act_ctl, act_be, act_sc, act_fc, e.ctl, e.be, e.sc, e.fc);
  endtask

  initial begin
    rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; id_u1 = 0; id_u2 = 0;
    ex_rd = '0; ex_mr = 0; ex_pcs = '0; mreq = 0; mrdy = 0;

    // reset and basic pass
    vecs.push_back(mk("reset", 0, 1'b0, 0,0, 0,0, 0,0, 0, 0,0, RSTO, 0, 0, 0));
    vecs.push_back(idle("idle", 0, PASS, 0, 0, 0));
    // load-use via rs1, then bubble in EX
    vecs.push_back(mk("lu_rs1", 0, 1, 5,1, 1,1, 5,1, 0, 0,0, STALL, 0, 0, 0));
    vecs.push_back(mk("lu_rs1_after", 0, 1, 5,1, 1,1, 0,0, 0, 0,0, PASS, 0, 1, 0));
    // x0 and unused rs2 never hazard
    vecs.push_back(mk("x0_load", 0, 1, 0,1, 0,1, 0,1, 0, 0,0, PASS, 0, 1, 0));
    vecs.push_back(mk("rs2_unused", 0, 1, 3,1, 7,0, 7,1, 0, 0,0, PASS, 0, 1, 0));
    vecs.push_back(mk("lu_rs2", 0, 1, 3,1, 7,1, 7,1, 0, 0,0, STALL, 0, 1, 0));
    vecs.push_back(mk("lu_rs2_after", 0, 1, 3,1, 7,1, 0,0, 0, 0,0, PASS, 0, 2, 0));
    // redirect beats load-use
    vecs.push_back(mk("redir_vs_lu", 0, 1, 5,1, 0,0, 5,1, 2, 0,0, FLUSH, 0, 2, 0));
    vecs.push_back(idle("redir_after", 0, PASS, 0, 2, 1));
    // mem wait beats redirect; release is zero-latency and evaluated as RUN
    vecs.push_back(mk("mw_vs_redir", 0, 1, 0,0, 0,0, 0,0, 1, 1,0, HOLD, 0, 2, 1));
    vecs.push_back(memw("mw2", 0, HOLD, 0, 2, 1));
    vecs.push_back(memw("mw3", 0, HOLD, 0, 2, 1));
    vecs.push_back(memw("mw4", 0, HOLD, 0, 2, 1));
    vecs.push_back(mk("mw_release", 0, 1, 0,0, 0,0, 0,0, 1, 1,1, FLUSH, 0, 2, 1));
    vecs.push_back(idle("mw_after", 0, PASS, 0, 2, 2));
    // timeout: 1 RUN cycle + 15 MEM_WAIT cycles of HOLD
    for (int i = 0; i < 16; i++)
      vecs.push_back(memw($sformatf("to_hold%0d", i), 0, HOLD, 0, 2, 2));
    vecs.push_back(memw("to_masked", 0, PASS, 1, 2, 2));
    vecs.push_back(memw("to_rewait", 0, HOLD, 1, 2, 2));
    vecs.push_back(memw("to_ready", 1, PASS, 1, 2, 2));
    vecs.push_back(idle("berr_sticky", 0, PASS, 1, 2, 2));
    // async reset in the middle of a memory wait
    vecs.push_back(memw("pre_rst_wait", 0, HOLD, 1, 2, 2));
    vecs.push_back(mk("rst_mid_wait", 0, 1'b0, 0,0, 0,0, 0,0, 0, 1,0, RSTO, 0, 0, 0));
    vecs.push_back(idle("rst_release", 0, PASS, 0, 0, 0));

    // three-bubble load-use instance
    vecs.push_back(mk("l3_reset", 1, 1'b0, 0,0, 0,0, 0,0, 0, 0,0, RSTO, 0, 0, 0));
    vecs.push_back(mk("l3_lu", 1, 1, 5,1, 1,1, 5,1, 0, 0,0, STALL, 0, 0, 0));
    vecs.push_back(mk("l3_st2", 1, 1, 5,1, 1,1, 0,0, 0, 0,0, STALL, 0, 1, 0));
    vecs.push_back(mk("l3_st3", 1, 1, 5,1, 1,1, 0,0, 0, 0,0, STALL, 0, 2, 0));
    vecs.push_back(mk("l3_pass", 1, 1, 5,1, 1,1, 0,0, 0, 0,0, PASS, 0, 3, 0));
    // mem wait freezes the stall sequence
    vecs.push_back(mk("l3_lu_b", 1, 1, 5,1, 1,1, 5,1, 0, 0,0, STALL, 0, 3, 0));
    vecs.push_back(mk("l3_frozen", 1, 1, 5,1, 1,1, 0,0, 0, 1,0, HOLD, 0, 4, 0));
    vecs.push_back(mk("l3_resume2", 1, 1, 5,1, 1,1, 0,0, 0, 1,1, STALL, 0, 4, 0));
    vecs.push_back(mk("l3_resume3", 1, 1, 5,1, 1,1, 0,0, 0, 0,0, STALL, 0, 5, 0));
    vecs.push_back(mk("l3_done", 1, 1, 5,1, 1,1, 0,0, 0, 0,0, PASS, 0, 6, 0));

    foreach (vecs[i]) apply(vecs[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
